// File: rtl/food_gen.sv
// Food placement for the snake game: draws LFSR candidates on request, rejects
// out-of-range or occupied cells by scanning the body serially, then commits.
module food_gen #(
  parameter logic [4:0] X_MAX     = 5'd29,
  parameter logic [4:0] Y_MAX     = 5'd29,
  parameter logic [4:0] INIT_X    = 5'd20,
  parameter logic [4:0] INIT_Y    = 5'd20,
  parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   game_state,
  input  logic         pause,
  input  logic         get_food,
  input  logic [319:0] snake_x_1dim,
  input  logic [319:0] snake_y_1dim,
  input  logic [5:0]   snake_length,
  output logic [4:0]   food_x,
  output logic [4:0]   food_y,
  output logic         food_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, GEN, SCAN, COMMIT} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  lfsr_reg, lfsr_next;
  logic        get_food_d;
  logic [5:0]  idx_reg, idx_next;
  logic [4:0]  cand_x_reg, cand_x_next;
  logic [4:0]  cand_y_reg, cand_y_next;
  logic [4:0]  food_x_next, food_y_next;
  logic        food_valid_next;
  logic        request;
  logic        run_mode;
  logic        init_mode;
  logic [4:0]  lfsr_x, lfsr_y;
  logic [8:0]  seg_base;
  logic [4:0]  seg_x, seg_y;
  logic        last_seg;

  // x^10 + x^7 + 1, Fibonacci form shifting toward the MSB
  assign lfsr_next = {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
  assign lfsr_x    = lfsr_reg[4:0];
  assign lfsr_y    = lfsr_reg[9:5];

  assign init_mode = (game_state == 2'b10);
  assign run_mode  = (game_state == 2'b00) && !pause;
  assign request   = get_food && !get_food_d;

  // Body vectors are read live; segment idx occupies bits [5*idx+4 : 5*idx]
  assign seg_base = {3'b000, idx_reg} * 9'd5;
  assign seg_x    = snake_x_1dim[seg_base +: 5];
  assign seg_y    = snake_y_1dim[seg_base +: 5];
  // Written as >= so a body that shrinks mid-scan still terminates the walk
  assign last_seg = ({1'b0, idx_reg} + 7'd1) >= {1'b0, snake_length};

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cand_x_next     = cand_x_reg;
    cand_y_next     = cand_y_reg;
    food_x_next     = food_x;
    food_y_next     = food_y;
    food_valid_next = food_valid;

    if (init_mode) begin
      state_next      = IDLE;
      food_x_next     = INIT_X;
      food_y_next     = INIT_Y;
      food_valid_next = 1'b1;
    end else if (run_mode) begin
      case (state_reg)
        IDLE: begin
          if (request) begin
            state_next      = GEN;
            food_valid_next = 1'b0;
          end
        end
        GEN: begin
          if (lfsr_x <= X_MAX && lfsr_y <= Y_MAX) begin
            cand_x_next = lfsr_x;
            cand_y_next = lfsr_y;
            idx_next    = 6'd0;
            state_next  = (snake_length == 6'd0) ? COMMIT : SCAN;
          end
        end
        SCAN: begin
          if (seg_x == cand_x_reg && seg_y == cand_y_reg) begin
            state_next = GEN;
          end else if (last_seg) begin
            state_next = COMMIT;
          end else begin
            idx_next = idx_reg + 6'd1;
          end
        end
        COMMIT: begin
          food_x_next     = cand_x_reg;
          food_y_next     = cand_y_reg;
          food_valid_next = 1'b1;
          state_next      = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      lfsr_reg   <= LFSR_SEED;
      get_food_d <= 1'b0;
      idx_reg    <= 6'd0;
      cand_x_reg <= 5'd0;
      cand_y_reg <= 5'd0;
      food_x     <= INIT_X;
      food_y     <= INIT_Y;
      food_valid <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lfsr_reg   <= lfsr_next;
      get_food_d <= get_food;
      idx_reg    <= idx_next;
      cand_x_reg <= cand_x_next;
      cand_y_reg <= cand_y_next;
      food_x     <= food_x_next;
      food_y     <= food_y_next;
      food_valid <= food_valid_next;
      busy       <= (state_next != IDLE);
    end
  end

endmodule
